// File: rtl/mem_bus_arbiter.sv
// Arbitrates the fetch and data ports onto one single-port memory bus.
// Optional watchdog: define MEM_ARB_TIMEOUT_EN.
module mem_bus_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_addr_valid,
  output logic [DATA_W-1:0] imem_data,
  output logic              imem_data_valid,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic [DATA_W-1:0] dmem_dout,
  output logic [DATA_W-1:0] dmem_din,
  input  logic [1:0]        dmem_write_width,
  input  logic              dmem_rstrobe,
  input  logic              dmem_wstrobe,
  output logic              dmem_cycle_complete,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [1:0]        bus_width,
  output logic              bus_rd,
  output logic              bus_wr,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack,
  output logic              bus_err
);

  typedef enum logic [1:0] {
    IDLE,
    BUS_FETCH,
    BUS_DATA
  } state_e;

  state_e state_q, state_d;
  logic last_fetch_q, last_fetch_d;

  logic              pend_q, pend_d;
  logic              pend_wr_q, pend_wr_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [DATA_W-1:0] pend_wdata_q, pend_wdata_d;
  logic [1:0]        pend_width_q, pend_width_d;

  logic [DATA_W-1:0] imem_data_q, imem_data_d;
  logic              imem_vld_q, imem_vld_d;
  logic [DATA_W-1:0] dmem_din_q, dmem_din_d;
  logic              dmem_done_q, dmem_done_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [1:0]        bus_width_q, bus_width_d;
  logic              bus_rd_q, bus_rd_d;
  logic              bus_wr_q, bus_wr_d;
  logic              bus_err_q, bus_err_d;

  logic tmo;
  logic fetch_go;
  logic done;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 255) ?
                         $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign tmo = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  localparam int unused_tmo = TIMEOUT_CYCLES;
  assign tmo = 1'b0;
`endif

  assign fetch_go = imem_addr_valid && (!pend_q || !last_fetch_q);
  assign done     = bus_ack || tmo;

  always_comb begin
    state_d      = state_q;
    last_fetch_d = last_fetch_q;
    pend_d       = pend_q;
    pend_wr_d    = pend_wr_q;
    pend_addr_d  = pend_addr_q;
    pend_wdata_d = pend_wdata_q;
    pend_width_d = pend_width_q;
    imem_data_d  = imem_data_q;
    imem_vld_d   = 1'b0;
    dmem_din_d   = dmem_din_q;
    dmem_done_d  = 1'b0;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    bus_width_d  = bus_width_q;
    bus_rd_d     = bus_rd_q;
    bus_wr_d     = bus_wr_q;
    bus_err_d    = bus_err_q;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d        = cnt_q + 1'b1;
`endif

    if (!pend_q && (dmem_rstrobe || dmem_wstrobe)) begin
      pend_d       = 1'b1;
      pend_wr_d    = dmem_wstrobe;
      pend_addr_d  = dmem_addr;
      pend_wdata_d = dmem_dout;
      pend_width_d = dmem_write_width;
    end

    unique case (state_q)
      IDLE: begin
`ifdef MEM_ARB_TIMEOUT_EN
        cnt_d = '0;
`endif
        if (fetch_go) begin
          bus_addr_d   = imem_addr;
          bus_width_d  = 2'd3;
          bus_rd_d     = 1'b1;
          last_fetch_d = 1'b1;
          state_d      = BUS_FETCH;
        end else if (pend_q) begin
          bus_addr_d   = pend_addr_q;
          bus_wdata_d  = pend_wdata_q;
          bus_width_d  = pend_width_q;
          bus_rd_d     = !pend_wr_q;
          bus_wr_d     = pend_wr_q;
          last_fetch_d = 1'b0;
          state_d      = BUS_DATA;
        end
      end
      BUS_FETCH: begin
        if (done) begin
          bus_rd_d = 1'b0;
          state_d  = IDLE;
          if (tmo && !bus_ack) bus_err_d = 1'b1;
          // a redirected or withdrawn fetch drops the stale data
          if (imem_addr_valid && imem_addr == bus_addr_q) begin
            imem_vld_d  = 1'b1;
            imem_data_d = bus_ack ? bus_rdata : '0;
          end
        end
      end
      BUS_DATA: begin
        if (done) begin
          bus_rd_d    = 1'b0;
          bus_wr_d    = 1'b0;
          pend_d      = 1'b0;
          dmem_done_d = 1'b1;
          state_d     = IDLE;
          if (tmo && !bus_ack) bus_err_d = 1'b1;
          if (!bus_wr_q) dmem_din_d = bus_ack ? bus_rdata : '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_fetch_q <= 1'b0;
      pend_q       <= 1'b0;
      pend_wr_q    <= 1'b0;
      pend_addr_q  <= '0;
      pend_wdata_q <= '0;
      pend_width_q <= '0;
      imem_data_q  <= '0;
      imem_vld_q   <= 1'b0;
      dmem_din_q   <= '0;
      dmem_done_q  <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      bus_width_q  <= '0;
      bus_rd_q     <= 1'b0;
      bus_wr_q     <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_fetch_q <= last_fetch_d;
      pend_q       <= pend_d;
      pend_wr_q    <= pend_wr_d;
      pend_addr_q  <= pend_addr_d;
      pend_wdata_q <= pend_wdata_d;
      pend_width_q <= pend_width_d;
      imem_data_q  <= imem_data_d;
      imem_vld_q   <= imem_vld_d;
      dmem_din_q   <= dmem_din_d;
      dmem_done_q  <= dmem_done_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      bus_width_q  <= bus_width_d;
      bus_rd_q     <= bus_rd_d;
      bus_wr_q     <= bus_wr_d;
      bus_err_q    <= bus_err_d;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

  assign imem_data           = imem_data_q;
  assign imem_data_valid     = imem_vld_q;
  assign dmem_din            = dmem_din_q;
  assign dmem_cycle_complete = dmem_done_q;
  assign bus_addr            = bus_addr_q;
  assign bus_wdata           = bus_wdata_q;
  assign bus_width           = bus_width_q;
  assign bus_rd              = bus_rd_q;
  assign bus_wr              = bus_wr_q;
  assign bus_err             = bus_err_q;

endmodule
